// File: rtl/scmp_status.sv
// ----------------------------------------------------------------------------
// scmp_status -- SC/MP-style processor status register and interrupt request.
//
// Holds the architectural status byte {CY, OV, SB, SA, IE, F2, F1, F0}, the
// hidden half-carry HCY used by decimal adjust, and the registered interrupt
// request raised when interrupts are enabled and sense input SA is high.
//
// Parameters:
//   IE_RESET   value of IE after reset
//
// Configuration macro:
//   SCMP_SENSE_SYNC_EN  when defined, sa_i/sb_i pass through a 2-flop
//                       synchroniser (sr_o[5:4] lag 2 cycles, int_req_o lag 3);
//                       otherwise a single register stage is used (lag 1 / 2).
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   alu_cy_i/alu_ov_i/alu_hcy_i   flag results from the ALU stage
//   ld_cy/ld_ov/ld_hcy            per-flag load strobes (beat sr_wr)
//   sr_wr, sr_d                   status register write (CAS)
//   ie_set, ie_clr                IEN / DINT strobes
//   sa_i, sb_i                    asynchronous sense inputs
//   int_ack                       interrupt-accept pulse
//   sr_o                          status byte
//   cy_o, ov_o, hcy_o             flags fed back to the ALU
//   ie_o                          interrupt enable
//   flag_o                        F2..F0 user flag pins
//   int_req_o                     registered interrupt request
//
// Every output is a flop output; no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module scmp_status #(
  parameter logic IE_RESET = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_cy_i,
  input  logic       alu_ov_i,
  input  logic       alu_hcy_i,
  input  logic       ld_cy,
  input  logic       ld_ov,
  input  logic       ld_hcy,
  input  logic       sr_wr,
  input  logic [7:0] sr_d,
  input  logic       ie_set,
  input  logic       ie_clr,
  input  logic       sa_i,
  input  logic       sb_i,
  input  logic       int_ack,
  output logic [7:0] sr_o,
  output logic       cy_o,
  output logic       ov_o,
  output logic       hcy_o,
  output logic       ie_o,
  output logic [2:0] flag_o,
  output logic       int_req_o
);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic       cy_q,   cy_d;
  logic       ov_q,   ov_d;
  logic       hcy_q,  hcy_d;
  logic       ie_q,   ie_d;
  logic [2:0] flag_q, flag_d;
  logic       int_req_q, int_req_d;

  // Synchronised sense inputs as seen by the rest of the block.
  logic       sa_sync;
  logic       sb_sync;

  // sr_d[5:4] address the read-only sense bits; writes to them are dropped.
  logic       unused_sr_d;
  assign unused_sr_d = ^sr_d[5:4];

  // --------------------------------------------------------------------------
  // Sense input synchronisers
  // --------------------------------------------------------------------------
`ifdef SCMP_SENSE_SYNC_EN
  logic sa_s1_q, sa_s2_q;
  logic sb_s1_q, sb_s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_s1_q <= 1'b0;
      sa_s2_q <= 1'b0;
      sb_s1_q <= 1'b0;
      sb_s2_q <= 1'b0;
    end else begin
      sa_s1_q <= sa_i;
      sa_s2_q <= sa_s1_q;
      sb_s1_q <= sb_i;
      sb_s2_q <= sb_s1_q;
    end
  end

  assign sa_sync = sa_s2_q;
  assign sb_sync = sb_s2_q;
`else
  logic sa_s1_q;
  logic sb_s1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa_s1_q <= 1'b0;
      sb_s1_q <= 1'b0;
    end else begin
      sa_s1_q <= sa_i;
      sb_s1_q <= sb_i;
    end
  end

  assign sa_sync = sa_s1_q;
  assign sb_sync = sb_s1_q;
`endif

  // --------------------------------------------------------------------------
  // Flag next-state: per-bit load strobe beats the whole-register write
  // --------------------------------------------------------------------------
  always_comb begin
    cy_d   = cy_q;
    ov_d   = ov_q;
    hcy_d  = hcy_q;
    flag_d = flag_q;

    if (ld_cy) begin
      cy_d = alu_cy_i;
    end else if (sr_wr) begin
      cy_d = sr_d[7];
    end

    if (ld_ov) begin
      ov_d = alu_ov_i;
    end else if (sr_wr) begin
      ov_d = sr_d[6];
    end

    // HCY is not architecturally visible, so sr_wr never touches it.
    if (ld_hcy) begin
      hcy_d = alu_hcy_i;
    end

    if (sr_wr) begin
      flag_d = sr_d[2:0];
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt enable: accept/DINT clear beats IEN, which beats CAS
  // --------------------------------------------------------------------------
  always_comb begin
    ie_d = ie_q;
    if (int_ack || ie_clr) begin
      ie_d = 1'b0;
    end else if (ie_set) begin
      ie_d = 1'b1;
    end else if (sr_wr) begin
      ie_d = sr_d[3];
    end
  end

  // --------------------------------------------------------------------------
  // Interrupt request: level-sensitive on IE & SA, dropped by accept.
  // Because accept also clears IE, the request cannot return until IE is
  // set again, even while SA stays high.
  // --------------------------------------------------------------------------
  always_comb begin
    if (int_ack) begin
      int_req_d = 1'b0;
    end else begin
      int_req_d = ie_q & sa_sync;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cy_q      <= 1'b0;
      ov_q      <= 1'b0;
      hcy_q     <= 1'b0;
      ie_q      <= IE_RESET;
      flag_q    <= 3'b000;
      int_req_q <= 1'b0;
    end else begin
      cy_q      <= cy_d;
      ov_q      <= ov_d;
      hcy_q     <= hcy_d;
      ie_q      <= ie_d;
      flag_q    <= flag_d;
      int_req_q <= int_req_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign sr_o      = {cy_q, ov_q, sb_sync, sa_sync, ie_q, flag_q};
  assign cy_o      = cy_q;
  assign ov_o      = ov_q;
  assign hcy_o     = hcy_q;
  assign ie_o      = ie_q;
  assign flag_o    = flag_q;
  assign int_req_o = int_req_q;

endmodule

// File: tb/tb_scmp_status.sv
module tb_scmp_status;

`ifdef SCMP_SENSE_SYNC_EN
  localparam int SaLat = 2;
`else
  localparam int SaLat = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       alu_cy_i = 1'b0, alu_ov_i = 1'b0, alu_hcy_i = 1'b0;
  logic       ld_cy = 1'b0, ld_ov = 1'b0, ld_hcy = 1'b0;
  logic       sr_wr = 1'b0;
  logic [7:0] sr_d = 8'h00;
  logic       ie_set = 1'b0, ie_clr = 1'b0;
  logic       sa_i = 1'b0, sb_i = 1'b0;
  logic       int_ack = 1'b0;
  logic [7:0] sr_o;
  logic       cy_o, ov_o, hcy_o, ie_o;
  logic [2:0] flag_o;
  logic       int_req_o;

  int total = 0;
  int bad   = 0;

  scmp_status #(.IE_RESET(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_cy_i  (alu_cy_i),
    .alu_ov_i  (alu_ov_i),
    .alu_hcy_i (alu_hcy_i),
    .ld_cy     (ld_cy),
    .ld_ov     (ld_ov),
    .ld_hcy    (ld_hcy),
    .sr_wr     (sr_wr),
    .sr_d      (sr_d),
    .ie_set    (ie_set),
    .ie_clr    (ie_clr),
    .sa_i      (sa_i),
    .sb_i      (sb_i),
    .int_ack   (int_ack),
    .sr_o      (sr_o),
    .cy_o      (cy_o),
    .ov_o      (ov_o),
    .hcy_o     (hcy_o),
    .ie_o      (ie_o),
    .flag_o    (flag_o),
    .int_req_o (int_req_o)
  );

  always #5 clk = ~clk;

  // One rising edge, then settle; inputs change only here, away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_sr(input logic [7:0] d);
    sr_wr = 1'b1; sr_d = d;
    tick();
    sr_wr = 1'b0; sr_d = 8'h00;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if (sr_o !== 8'h00) begin bad++; $display("FAIL reset_sr got=%h want=00", sr_o); end
    total++;
    if ({cy_o, ov_o, hcy_o, ie_o, flag_o, int_req_o} !== 8'h00) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000000",
               {cy_o, ov_o, hcy_o, ie_o, flag_o, int_req_o});
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (sr_o !== 8'h00) begin bad++; $display("FAIL post_reset_sr got=%h want=00", sr_o); end
  endtask

  task automatic test_sr_write;
    write_sr(8'hFF);
    total++;
    if (sr_o !== 8'hCF) begin bad++; $display("FAIL wr_ff_sr got=%h want=cf", sr_o); end
    total++;
    if (flag_o !== 3'b111) begin bad++; $display("FAIL wr_ff_flag got=%b want=111", flag_o); end
    total++;
    if ({cy_o, ov_o, ie_o} !== 3'b111) begin
      bad++; $display("FAIL wr_ff_bits got=%b want=111", {cy_o, ov_o, ie_o});
    end
    write_sr(8'h35);
    total++;
    if (sr_o !== 8'h05) begin bad++; $display("FAIL wr_35_sr got=%h want=05", sr_o); end
  endtask

  task automatic test_priority;
    write_sr(8'hFF);
    // ld_cy beats sr_wr for CY; OV and IE follow sr_d.
    ld_cy = 1'b1; alu_cy_i = 1'b1; sr_wr = 1'b1; sr_d = 8'h00;
    tick();
    ld_cy = 1'b0; alu_cy_i = 1'b0; sr_wr = 1'b0;
    total++;
    if ({cy_o, ov_o, ie_o} !== 3'b100) begin
      bad++; $display("FAIL ldcy_vs_wr got=%b want=100", {cy_o, ov_o, ie_o});
    end
    // ld_ov loading 0 beats sr_wr writing 1.
    ld_ov = 1'b1; alu_ov_i = 1'b0; sr_wr = 1'b1; sr_d = 8'hFF;
    tick();
    ld_ov = 1'b0; sr_wr = 1'b0; sr_d = 8'h00;
    total++;
    if (sr_o !== 8'h8F) begin bad++; $display("FAIL ldov_vs_wr got=%h want=8f", sr_o); end
    write_sr(8'h00);
  endtask

  task automatic test_ie;
    ie_set = 1'b1; ie_clr = 1'b1;
    tick();
    ie_clr = 1'b0;
    total++;
    if (ie_o !== 1'b0) begin bad++; $display("FAIL ie_set_clr got=%b want=0", ie_o); end
    tick();
    ie_set = 1'b0;
    total++;
    if (ie_o !== 1'b1) begin bad++; $display("FAIL ie_set got=%b want=1", ie_o); end
    // ie_clr beats sr_wr writing IE=1.
    ie_clr = 1'b1; sr_wr = 1'b1; sr_d = 8'h08;
    tick();
    ie_clr = 1'b0; sr_wr = 1'b0; sr_d = 8'h00;
    total++;
    if (ie_o !== 1'b0) begin bad++; $display("FAIL ieclr_vs_wr got=%b want=0", ie_o); end
    // ie_set beats sr_wr writing IE=0.
    ie_set = 1'b1; sr_wr = 1'b1; sr_d = 8'h00;
    tick();
    ie_set = 1'b0; sr_wr = 1'b0;
    total++;
    if (ie_o !== 1'b1) begin bad++; $display("FAIL ieset_vs_wr got=%b want=1", ie_o); end
    // Accept with no request pending: only IE clears.
    write_sr(8'hCD);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++;
    if (sr_o !== 8'hC5 || int_req_o !== 1'b0) begin
      bad++; $display("FAIL ack_idle got=%h/%b want=c5/0", sr_o, int_req_o);
    end
    write_sr(8'h00);
  endtask

  task automatic test_sense;
    sb_i = 1'b1;
    #1;
    total++;
    if (sr_o[5] !== 1'b0) begin bad++; $display("FAIL sb_comb got=%b want=0", sr_o[5]); end
    tick(SaLat);
    total++;
    if (sr_o !== 8'h20) begin bad++; $display("FAIL sb_lat got=%h want=20", sr_o); end
    sb_i = 1'b0;
    tick(SaLat);
    total++;
    if (sr_o !== 8'h00) begin bad++; $display("FAIL sb_fall got=%h want=00", sr_o); end
  endtask

  task automatic test_interrupt;
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    sa_i = 1'b1;
    tick(SaLat);
    total++;
    if (int_req_o !== 1'b0 || sr_o[4] !== 1'b1) begin
      bad++; $display("FAIL irq_early got=%b/%b want=0/1", int_req_o, sr_o[4]);
    end
    tick();
    total++;
    if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b want=1", int_req_o); end
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    total++;
    if (int_req_o !== 1'b0 || ie_o !== 1'b0) begin
      bad++; $display("FAIL irq_ack got=%b/%b want=0/0", int_req_o, ie_o);
    end
    tick(3);
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_rearm got=%b want=0", int_req_o); end
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_ie_lag got=%b want=0", int_req_o); end
    tick();
    total++;
    if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_again got=%b want=1", int_req_o); end
    // SA drops before accept: request follows the synchronised level.
    sa_i = 1'b0;
    tick(SaLat);
    total++;
    if (int_req_o !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b want=1", int_req_o); end
    tick();
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL irq_sa_drop got=%b want=0", int_req_o); end
    ie_clr = 1'b1;
    tick();
    ie_clr = 1'b0;
  endtask

  task automatic test_hcy_async_reset;
    ld_hcy = 1'b1; alu_hcy_i = 1'b1;
    tick();
    ld_hcy = 1'b0; alu_hcy_i = 1'b0;
    write_sr(8'h00);
    total++;
    if (hcy_o !== 1'b1) begin bad++; $display("FAIL hcy_keep got=%b want=1", hcy_o); end
    write_sr(8'hFF);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (hcy_o !== 1'b0 || sr_o !== 8'h00) begin
      bad++; $display("FAIL async_rst got=%b/%h want=0/00", hcy_o, sr_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_handshake;
    ie_set = 1'b1; sa_i = 1'b1;
    tick();
    ie_set = 1'b0;
    tick(SaLat + 1);
    total++;
    if (int_req_o !== 1'b1) begin bad++; $display("FAIL hs_req got=%b want=1", int_req_o); end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL hs_rst got=%b want=0", int_req_o); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(4);
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL hs_noie got=%b want=0", int_req_o); end
    ie_set = 1'b1;
    tick();
    ie_set = 1'b0;
    total++;
    if (int_req_o !== 1'b0) begin bad++; $display("FAIL hs_fresh0 got=%b want=0", int_req_o); end
    tick();
    total++;
    if (int_req_o !== 1'b1) begin bad++; $display("FAIL hs_fresh1 got=%b want=1", int_req_o); end
    sa_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sr_write();
    test_priority();
    test_ie();
    test_sense();
    test_interrupt();
    test_hcy_async_reset();
    test_reset_mid_handshake();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scmp_status.md
SCMP_STATUS -- requirements
Module: scmp_status

Interface
REQ-001 Parameter IE_RESET, default 1'b0: value of the IE bit after reset.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 alu_cy_i, alu_ov_i, alu_hcy_i  input  1 each  carry, overflow and half-carry results from the ALU stage.
REQ-005 ld_cy, ld_ov, ld_hcy  input  1 each  per-flag load strobes from the microcode sequencer.
REQ-006 sr_wr  input  1  strobe to write the status register from sr_d (CAS).
REQ-007 sr_d  input  8  write data for the status register.
REQ-008 ie_set, ie_clr  input  1 each  interrupt-enable set (IEN) and clear (DINT) strobes.
REQ-009 sa_i, sb_i  input  1 each  asynchronous sense inputs.
REQ-010 int_ack  input  1  interrupt-accept pulse from the sequencer.
REQ-011 sr_o  output  8  status register {CY, OV, SB, SA, IE, F2, F1, F0}.
REQ-012 cy_o, ov_o, hcy_o  output  1 each  current CY, OV and hidden half-carry, fed back to the ALU as Cy_i, Ov_i and HCy_i.
REQ-013 ie_o  output  1  current interrupt enable.
REQ-014 flag_o  output  3  F2..F0 user flag pins.
REQ-015 int_req_o  output  1  registered interrupt request to the sequencer.

Function
REQ-016 Per-bit write priority, highest first: ld_* strobe, then sr_wr, then hold.
REQ-017 ld_cy loads CY from alu_cy_i; ld_ov loads OV from alu_ov_i; ld_hcy loads hidden HCY from alu_hcy_i; each loads on the edge its strobe is high.
REQ-018 sr_wr loads CY, OV, IE and F2..F0 from sr_d[7], sr_d[6], sr_d[3] and sr_d[2:0]; sr_d[5:4] is ignored; HCY is not affected.
REQ-019 IE priority, highest first: int_ack or ie_clr clears; then ie_set sets; then sr_wr loads; then hold.
REQ-020 sr_o[5:4] show the synchronised SB and SA and are read-only.
REQ-021 int_req_o is registered: it is set on the edge after IE=1 and synchronised SA=1 are both true.
REQ-022 int_req_o stays high until the edge on which int_ack is sampled high, then goes low.
REQ-023 int_req_o is not re-asserted until IE is set again.
REQ-024 int_ack with int_req_o low clears IE and has no other effect.
REQ-025 If SA drops before int_ack, int_req_o goes low on the next edge (level-sensitive request).
REQ-026 All outputs are direct register outputs; there is no combinational path from any input to any output.
REQ-027 A sr_wr followed by a read shows the new value one cycle after the write edge.

Reset
REQ-028 On rst high, the following clear to 0 immediately, independent of clk: CY, OV, HCY, F2..F0, int_req_o and all synchroniser stages.
REQ-029 On rst high, IE takes the value IE_RESET immediately.
REQ-030 Reset asserted mid-interrupt-handshake drops int_req_o at once.
REQ-031 After reset release, an interrupt request needs a fresh IE=1 and SA=1 evaluation.

Configuration
REQ-032 With SCMP_SENSE_SYNC_EN defined, sa_i and sb_i each pass through a 2-flop synchroniser: sr_o[5:4] lag by 2 cycles and int_req_o by 3 cycles from the input edge.
REQ-033 Without SCMP_SENSE_SYNC_EN, a single register stage is used: sr_o[5:4] lag by 1 cycle and int_req_o by 2 cycles.

Verification
REQ-034 Reset then sr_wr, sr_d=8'hFF -> sr_o = 8'hCF with sa_i=sb_i=0, and flag_o=3'b111.
REQ-035 ld_cy=1, alu_cy_i=1 and sr_wr with sr_d=8'h00 in the same cycle -> cy_o=1, ov_o=0, ie_o=0.
REQ-036 ie_set, then sa_i rises at cycle T -> int_req_o high at T+3 (macro on) or T+2 (macro off); int_ack pulse -> int_req_o low and ie_o low on the next edge.
REQ-037 ie_set and ie_clr asserted together -> ie_o=0; then ie_set alone -> ie_o=1 one cycle later.
REQ-038 ld_hcy with alu_hcy_i=1, then sr_wr with sr_d=8'h00 -> hcy_o stays 1; rst pulse between clock edges -> hcy_o=0 and sr_o=8'h00 with no clock edge.
